// File: rtl/mixer_pkg.sv
// Shared constants, sample type and saturation helper for the stereo sample mixer.
package mixer_pkg;

  localparam int unsigned WORD_WIDTH_DEFAULT = 24;
  localparam int unsigned GAIN_WIDTH_DEFAULT = 8;
  // Gains are unsigned Q1.(GAIN_WIDTH-1): the MSB alone is 1.0.
  localparam int unsigned UNITY_GAIN = 1 << (GAIN_WIDTH_DEFAULT - 1);

  typedef logic signed [WORD_WIDTH_DEFAULT-1:0] sample_t;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                    input int unsigned      w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/sample_mixer_if.sv
// Sample/gain/result bundle between the mixer and its surroundings.
// SAMPLE_MIXER_METER_EN adds the peak meter outputs.
interface sample_mixer_if #(
  parameter int unsigned WORD_WIDTH = 24,
  parameter int unsigned GAIN_WIDTH = 8
);
  logic signed [WORD_WIDTH-1:0] live_l, live_r, track_l, track_r;
  logic        [GAIN_WIDTH-1:0] gain_live, gain_track;
  logic                         clip_clr;
  logic signed [WORD_WIDTH-1:0] mix_l, mix_r;
  logic                         mix_valid;
  logic                         clip_l, clip_r;
`ifdef SAMPLE_MIXER_METER_EN
  logic        [WORD_WIDTH-2:0] peak_l, peak_r;

  modport master (
    output live_l, live_r, track_l, track_r, gain_live, gain_track, clip_clr,
    input  mix_l, mix_r, mix_valid, clip_l, clip_r, peak_l, peak_r
  );
  modport slave (
    input  live_l, live_r, track_l, track_r, gain_live, gain_track, clip_clr,
    output mix_l, mix_r, mix_valid, clip_l, clip_r, peak_l, peak_r
  );
`else
  modport master (
    output live_l, live_r, track_l, track_r, gain_live, gain_track, clip_clr,
    input  mix_l, mix_r, mix_valid, clip_l, clip_r
  );
  modport slave (
    input  live_l, live_r, track_l, track_r, gain_live, gain_track, clip_clr,
    output mix_l, mix_r, mix_valid, clip_l, clip_r
  );
`endif
endinterface

// File: rtl/mixer_channel.sv
// One channel of the mixer: gain multiply, sum/rescale, saturate, sticky clip flag.
module mixer_channel
  import mixer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEFAULT,
  parameter int unsigned GAIN_WIDTH = GAIN_WIDTH_DEFAULT
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         s1_en_i,
  input  logic                         s2_en_i,
  input  logic                         s3_en_i,
  input  logic signed [WORD_WIDTH-1:0] live_i,
  input  logic signed [WORD_WIDTH-1:0] track_i,
  input  logic        [GAIN_WIDTH-1:0] gain_live_i,
  input  logic        [GAIN_WIDTH-1:0] gain_track_i,
  input  logic                         clip_clr_i,
  output logic signed [WORD_WIDTH-1:0] mix_o,
  output logic                         clip_o
);

  localparam int unsigned ProdW = WORD_WIDTH + GAIN_WIDTH + 1;
  localparam int unsigned SumW  = ProdW + 1;

  logic signed [ProdW-1:0]      p_live_d, p_live_q, p_trk_d, p_trk_q;
  logic signed [SumW-1:0]       sum_d, sh_d, sh_q;
  logic signed [63:0]           sh_wide, sh_clamped;
  logic signed [WORD_WIDTH-1:0] mix_d, mix_q;
  logic                         clipped, clip_d, clip_q;

  // Arithmetic for all three stages; gains are zero-extended so they stay non-negative.
  always_comb begin
    p_live_d   = $signed(ProdW'(live_i)) * $signed(ProdW'({1'b0, gain_live_i}));
    p_trk_d    = $signed(ProdW'(track_i)) * $signed(ProdW'({1'b0, gain_track_i}));
    sum_d      = $signed(SumW'(p_live_q)) + $signed(SumW'(p_trk_q));
    sh_d       = sum_d >>> (GAIN_WIDTH - 1);
    sh_wide    = 64'(sh_q);
    sh_clamped = sat_clamp(sh_wide, WORD_WIDTH);
    clipped    = (sh_clamped != sh_wide);
    mix_d      = sh_clamped[WORD_WIDTH-1:0];
    // A new clip in the output cycle beats a simultaneous clear.
    clip_d     = clip_clr_i ? 1'b0 : clip_q;
    if (s3_en_i && clipped) begin
      clip_d = 1'b1;
    end
  end

  // S1..S3 pipeline registers, each advancing only with its valid bit; clip flag every cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_live_q <= '0;
      p_trk_q  <= '0;
      sh_q     <= '0;
      mix_q    <= '0;
      clip_q   <= 1'b0;
    end else begin
      if (s1_en_i) begin
        p_live_q <= p_live_d;
        p_trk_q  <= p_trk_d;
      end
      if (s2_en_i) begin
        sh_q <= sh_d;
      end
      if (s3_en_i) begin
        mix_q <= mix_d;
      end
      clip_q <= clip_d;
    end
  end

  assign mix_o  = mix_q;
  assign clip_o = clip_q;

endmodule

// File: rtl/sample_mixer.sv
// Stereo two-source mixer: ws synchronizer, frame-edge detect, capture and valid pipeline.
// Define SAMPLE_MIXER_METER_EN to add the peak_l/peak_r meters.
module sample_mixer
  import mixer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH  = WORD_WIDTH_DEFAULT,
  parameter int unsigned GAIN_WIDTH  = GAIN_WIDTH_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           rst,
  input logic           ws,
  sample_mixer_if.slave bus
);

  logic [SYNC_STAGES-1:0]       sync_q;
  logic                         ws_prev_q;
  logic                         frame_evt;
  logic signed [WORD_WIDTH-1:0] live_l_q, live_r_q, track_l_q, track_r_q;
  logic        [GAIN_WIDTH-1:0] gain_live_q, gain_track_q;
  logic                         v0_q, v1_q, v2_q, mix_valid_q;

  // ws synchronizer plus a registered copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      ws_prev_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], ws};
      ws_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Both ws edges start a frame.
  assign frame_evt = sync_q[SYNC_STAGES-1] ^ ws_prev_q;

  // S0: snapshot samples and gains only on a frame event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_l_q     <= '0;
      live_r_q     <= '0;
      track_l_q    <= '0;
      track_r_q    <= '0;
      gain_live_q  <= '0;
      gain_track_q <= '0;
    end else if (frame_evt) begin
      live_l_q     <= bus.live_l;
      live_r_q     <= bus.live_r;
      track_l_q    <= bus.track_l;
      track_r_q    <= bus.track_r;
      gain_live_q  <= bus.gain_live;
      gain_track_q <= bus.gain_track;
    end
  end

  // Valid shift register; reset drops anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      mix_valid_q <= 1'b0;
    end else begin
      v0_q        <= frame_evt;
      v1_q        <= v0_q;
      v2_q        <= v1_q;
      mix_valid_q <= v2_q;
    end
  end

  assign bus.mix_valid = mix_valid_q;

  mixer_channel #(
    .WORD_WIDTH(WORD_WIDTH),
    .GAIN_WIDTH(GAIN_WIDTH)
  ) u_chan_l (
    .clk_i       (clk),
    .rst_i       (rst),
    .s1_en_i     (v0_q),
    .s2_en_i     (v1_q),
    .s3_en_i     (v2_q),
    .live_i      (live_l_q),
    .track_i     (track_l_q),
    .gain_live_i (gain_live_q),
    .gain_track_i(gain_track_q),
    .clip_clr_i  (bus.clip_clr),
    .mix_o       (bus.mix_l),
    .clip_o      (bus.clip_l)
  );

  mixer_channel #(
    .WORD_WIDTH(WORD_WIDTH),
    .GAIN_WIDTH(GAIN_WIDTH)
  ) u_chan_r (
    .clk_i       (clk),
    .rst_i       (rst),
    .s1_en_i     (v0_q),
    .s2_en_i     (v1_q),
    .s3_en_i     (v2_q),
    .live_i      (live_r_q),
    .track_i     (track_r_q),
    .gain_live_i (gain_live_q),
    .gain_track_i(gain_track_q),
    .clip_clr_i  (bus.clip_clr),
    .mix_o       (bus.mix_r),
    .clip_o      (bus.clip_r)
  );

`ifdef SAMPLE_MIXER_METER_EN
  logic [WORD_WIDTH-2:0] peak_l_d, peak_l_q, peak_r_d, peak_r_q;

  // |s| in WORD_WIDTH-1 bits; the most negative code saturates to full scale.
  function automatic logic [WORD_WIDTH-2:0] magnitude(input logic signed [WORD_WIDTH-1:0] s);
    logic signed [WORD_WIDTH-1:0] neg;
    neg = -s;
    if (s[WORD_WIDTH-1] && (s[WORD_WIDTH-2:0] == '0)) begin
      return '1;
    end
    return s[WORD_WIDTH-1] ? neg[WORD_WIDTH-2:0] : s[WORD_WIDTH-2:0];
  endfunction

  // Peak hold: clear first, then fold in the freshly published sample.
  always_comb begin
    peak_l_d = bus.clip_clr ? '0 : peak_l_q;
    peak_r_d = bus.clip_clr ? '0 : peak_r_q;
    if (mix_valid_q) begin
      if (magnitude(bus.mix_l) > peak_l_d) peak_l_d = magnitude(bus.mix_l);
      if (magnitude(bus.mix_r) > peak_r_d) peak_r_d = magnitude(bus.mix_r);
    end
  end

  // Peak registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_l_q <= '0;
      peak_r_q <= '0;
    end else begin
      peak_l_q <= peak_l_d;
      peak_r_q <= peak_r_d;
    end
  end

  assign bus.peak_l = peak_l_q;
  assign bus.peak_r = peak_r_q;
`endif

endmodule

// File: tb/tb_sample_mixer.sv
// Self-checking bench for sample_mixer: scoreboard of expected mixes checked on mix_valid.
module tb_sample_mixer;
  import mixer_pkg::*;

  localparam int unsigned WW  = 24;
  localparam int unsigned GW  = 8;
  localparam int unsigned SS  = 2;
  localparam int unsigned LAT = SS + 4;

  typedef struct packed {
    logic [WW-1:0] l;
    logic [WW-1:0] r;
    logic          cl;
    logic          cr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic ws;

  always #5 clk = ~clk;

  sample_mixer_if #(.WORD_WIDTH(WW), .GAIN_WIDTH(GW)) bus ();

  sample_mixer #(
    .WORD_WIDTH (WW),
    .GAIN_WIDTH (GW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ws (ws),
    .bus(bus)
  );

  exp_t          sb[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic          clip_l_m = 1'b0;
  logic          clip_r_m = 1'b0;
  logic [WW-1:0] last_l = '0;
  logic [WW-1:0] last_r = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference mix: gained sum, floor-shift, clamp.
  function automatic logic [WW-1:0] mix_model(input logic [WW-1:0] a, input logic [WW-1:0] b,
                                               input logic [GW-1:0] ga, input logic [GW-1:0] gb,
                                               output logic clipped);
    longint s;
    s = (longint'($signed(a)) * longint'(ga) + longint'($signed(b)) * longint'(gb)) >>> 7;
    clipped = 1'b0;
    if (s > 64'sd8388607) begin
      s = 64'sd8388607;
      clipped = 1'b1;
    end else if (s < -64'sd8388608) begin
      s = -64'sd8388608;
      clipped = 1'b1;
    end
    return s[WW-1:0];
  endfunction

  task automatic set_inputs(input logic [WW-1:0] ll, input logic [WW-1:0] tl,
                            input logic [WW-1:0] lr, input logic [WW-1:0] tr,
                            input logic [GW-1:0] gl, input logic [GW-1:0] gt);
    bus.live_l = ll; bus.track_l = tl; bus.live_r = lr; bus.track_r = tr;
    bus.gain_live = gl; bus.gain_track = gt;
  endtask

  task automatic push_expect(input logic [WW-1:0] ll, input logic [WW-1:0] tl,
                             input logic [WW-1:0] lr, input logic [WW-1:0] tr,
                             input logic [GW-1:0] gl, input logic [GW-1:0] gt);
    exp_t e;
    logic cl, cr;
    e.l = mix_model(ll, tl, gl, gt, cl);
    e.r = mix_model(lr, tr, gl, gt, cr);
    clip_l_m = clip_l_m | cl;
    clip_r_m = clip_r_m | cr;
    e.cl = clip_l_m;
    e.cr = clip_r_m;
    sb.push_back(e);
    last_l = e.l;
    last_r = e.r;
  endtask

  // One frame: drive inputs, toggle ws, then measure the latency to mix_valid.
  task automatic send_frame(input logic [WW-1:0] ll, input logic [WW-1:0] tl,
                            input logic [WW-1:0] lr, input logic [WW-1:0] tr,
                            input logic [GW-1:0] gl, input logic [GW-1:0] gt);
    int n;
    @(negedge clk);
    set_inputs(ll, tl, lr, tr, gl, gt);
    push_expect(ll, tl, lr, tr, gl, gt);
    ws = ~ws;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.mix_valid !== 1'b1 && n < 20);
    check_eq("latency", 64'(n), 64'(LAT));
  endtask

  task automatic clear_clips();
    @(negedge clk);
    bus.clip_clr = 1'b1;
    clip_l_m = 1'b0;
    clip_r_m = 1'b0;
    @(negedge clk);
    bus.clip_clr = 1'b0;
    check_eq("clip_l_cleared", 64'(bus.clip_l), 64'd0);
    check_eq("clip_r_cleared", 64'(bus.clip_r), 64'd0);
  endtask

  // Scoreboard: every mix_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t          e;
    logic [WW-1:0] got_l, got_r;
    if (rst === 1'b0 && bus.mix_valid === 1'b1) begin
      got_l = bus.mix_l;
      got_r = bus.mix_r;
      if (sb.size() == 0) begin
        check_eq("spurious_valid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check_eq("mix_l", 64'(got_l), 64'(e.l));
        check_eq("mix_r", 64'(got_r), 64'(e.r));
        check_eq("clip_l", 64'(bus.clip_l), 64'(e.cl));
        check_eq("clip_r", 64'(bus.clip_r), 64'(e.cr));
      end
    end
  end

  initial begin
    logic [WW-1:0] got_l, got_r;
    rst = 1'b1;
    ws  = 1'b0;
    bus.clip_clr = 1'b0;
    set_inputs('0, '0, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    check_eq("rst_mix_l", 64'(unsigned'(bus.mix_l)), 64'd0);
    check_eq("rst_mix_r", 64'(unsigned'(bus.mix_r)), 64'd0);
    check_eq("rst_valid", 64'(bus.mix_valid), 64'd0);
    check_eq("rst_clip_l", 64'(bus.clip_l), 64'd0);
    check_eq("rst_clip_r", 64'(bus.clip_r), 64'd0);
    rst = 1'b0;

    // Unity mix on both channels (right sums to a negative value).
    send_frame(24'h100000, 24'h080000, 24'h010000, 24'hFE0000, 8'h80, 8'h80);
    // Positive saturation on right, then a clean frame: clip_r must stick.
    send_frame(24'h000123, 24'h000000, 24'h700000, 24'h700000, 8'h80, 8'h80);
    send_frame(24'h000001, 24'h000002, 24'h000003, 24'h000004, 8'h80, 8'h80);
    check_eq("clip_r_sticky", 64'(bus.clip_r), 64'd1);
    clear_clips();
    // Negative saturation, floor of -1/2, mute of the track.
    send_frame(24'h800000, 24'hFFFFFF, 24'h000000, 24'h000000, 8'h80, 8'h80);
    send_frame(24'hFFFFFF, 24'h000000, 24'h000000, 24'h000000, 8'h40, 8'h00);
    send_frame(24'h200000, 24'h7FFFFF, 24'h000000, 24'h7FFFFF, 8'h40, 8'h00);
    // Max gains with full-scale inputs of both signs.
    send_frame(24'h7FFFFF, 24'h7FFFFF, 24'h800000, 24'h800000, 8'hFF, 8'hFF);
    clear_clips();
    for (int i = 0; i < 6; i++) begin
      send_frame(WW'($urandom), WW'($urandom), WW'($urandom), WW'($urandom),
                 GW'($urandom), GW'($urandom));
    end

    // Back-to-back frame events, one per cycle.
    @(negedge clk);
    set_inputs(24'h012345, 24'hFEDCBA, 24'h3FFFFF, 24'h400000, 8'hC0, 8'h20);
    for (int i = 0; i < 3; i++) begin
      push_expect(24'h012345, 24'hFEDCBA, 24'h3FFFFF, 24'h400000, 8'hC0, 8'h20);
    end
    ws = ~ws;
    @(negedge clk);
    ws = ~ws;
    @(negedge clk);
    ws = ~ws;
    repeat (12) @(negedge clk);

    // Input changes without a ws edge must not disturb the outputs.
    set_inputs(24'h111111, 24'h222222, 24'h333333, 24'h444444, 8'h11, 8'h22);
    repeat (10) @(negedge clk);
    got_l = bus.mix_l;
    got_r = bus.mix_r;
    check_eq("hold_mix_l", 64'(got_l), 64'(last_l));
    check_eq("hold_mix_r", 64'(got_r), 64'(last_r));

    // Reset while a frame is in flight: it must vanish.
    set_inputs(24'h700000, 24'h700000, 24'h700000, 24'h700000, 8'h80, 8'h80);
    ws = ~ws;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    ws = 1'b0;
    clip_l_m = 1'b0;
    clip_r_m = 1'b0;
    check_eq("midrst_mix_l", 64'(unsigned'(bus.mix_l)), 64'd0);
    check_eq("midrst_mix_r", 64'(unsigned'(bus.mix_r)), 64'd0);
    check_eq("midrst_valid", 64'(bus.mix_valid), 64'd0);
    check_eq("midrst_clip_l", 64'(bus.clip_l), 64'd0);
    check_eq("midrst_clip_r", 64'(bus.clip_r), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check_eq("postrst_mix_l", 64'(unsigned'(bus.mix_l)), 64'd0);
    send_frame(24'h100000, 24'h080000, 24'h000000, 24'h000000, 8'h80, 8'h80);

`ifdef SAMPLE_MIXER_METER_EN
    clear_clips();
    check_eq("peak_l_clr0", 64'(bus.peak_l), 64'd0);
    send_frame(24'h000100, 24'h000000, 24'h000000, 24'h000000, 8'h80, 8'h00);
    @(negedge clk);
    check_eq("peak_l_1", 64'(bus.peak_l), 64'h100);
    send_frame(24'hFFF000, 24'h000000, 24'h000000, 24'h000000, 8'h80, 8'h00);
    @(negedge clk);
    check_eq("peak_l_2", 64'(bus.peak_l), 64'h1000);
    send_frame(24'h000010, 24'h000000, 24'h000000, 24'h000000, 8'h80, 8'h00);
    @(negedge clk);
    check_eq("peak_l_3", 64'(bus.peak_l), 64'h1000);
    check_eq("peak_r_3", 64'(bus.peak_r), 64'h0);
    clear_clips();
    check_eq("peak_l_clr", 64'(bus.peak_l), 64'd0);
`endif

    repeat (10) @(negedge clk);
    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
